// File: rtl/i2s_frame_tracker.sv
// rtl/i2s_frame_tracker.sv - bit/slot position tracker for I2S or TDM serial audio
// Synchronises bclk/lrclk into clk, counts bit and slot position, and locks onto sync events.
module i2s_frame_tracker #(
  parameter int W_SLOT      = 32,
  parameter int N_SLOTS     = 2,
  parameter int SYNC_MODE   = 0,
  parameter int DELAY       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_SYNCS  = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        bclk,
  input  logic                                        lrclk,
  output logic                                        bit_tick,
  output logic [$clog2(W_SLOT)-1:0]                   bit_cnt,
  output logic [((N_SLOTS > 2) ? $clog2(N_SLOTS) : 1)-1:0] slot_cnt,
  output logic                                        slot_start,
  output logic                                        slot_last,
  output logic                                        frame_start,
  output logic                                        locked,
  output logic                                        err
);

  localparam int BW = $clog2(W_SLOT);
  localparam int SW = (N_SLOTS > 2) ? $clog2(N_SLOTS) : 1;
  localparam int GW = $clog2(LOCK_SYNCS + 1);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  localparam state_t FIRST = (LOCK_SYNCS <= 1) ? LOCKED : ACQUIRE;

  logic [SYNC_STAGES-1:0] bclk_sr, lrclk_sr;
  logic                   bclk_d, lr_prev, pend, pend_lvl;
  state_t                 state;
  logic [GW-1:0]          good_cnt, good_inc;

  logic          tick, lr_s, sync_edge, apply, app_lvl;
  logic          bit_wrap, slot_wrap, good_sync, missing, active, lock_now;
  logic [BW-1:0] nat_bit, nb;
  logic [SW-1:0] nat_slot, tgt_slot, ns;

  always_comb begin
    lr_s      = lrclk_sr[SYNC_STAGES-1];
    tick      = bclk_d & ~bclk_sr[SYNC_STAGES-1];
    sync_edge = (SYNC_MODE != 0) ? (lr_s & ~lr_prev) : (lr_s ^ lr_prev);
    apply     = (DELAY == 0) ? sync_edge : pend;
    app_lvl   = (DELAY == 0) ? lr_s : pend_lvl;
    bit_wrap  = (bit_cnt == BW'(W_SLOT - 1));
    slot_wrap = (slot_cnt == SW'(N_SLOTS - 1));
    nat_bit   = bit_wrap ? '0 : bit_cnt + 1'b1;
    nat_slot  = slot_cnt;
    if (bit_wrap) nat_slot = slot_wrap ? '0 : slot_cnt + 1'b1;
    // I2S: lrclk low selects the left slot (0), high the right slot (1)
    tgt_slot  = (SYNC_MODE != 0) ? '0 : SW'(app_lvl);
    good_sync = (nat_bit == '0) && (nat_slot == tgt_slot);
    missing   = bit_wrap && ((SYNC_MODE == 0) || slot_wrap);
    nb        = apply ? '0 : nat_bit;
    ns        = apply ? tgt_slot : nat_slot;
    active    = apply || (state != UNLOCKED);
    good_inc  = good_cnt + 1'b1;
    lock_now  = (good_inc >= GW'(LOCK_SYNCS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sr     <= '0;
      lrclk_sr    <= '0;
      bclk_d      <= 1'b0;
      lr_prev     <= 1'b0;
      pend        <= 1'b0;
      pend_lvl    <= 1'b0;
      state       <= UNLOCKED;
      good_cnt    <= '0;
      bit_tick    <= 1'b0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      slot_start  <= 1'b0;
      slot_last   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      bclk_sr     <= {bclk_sr[SYNC_STAGES-2:0], bclk};
      lrclk_sr    <= {lrclk_sr[SYNC_STAGES-2:0], lrclk};
      bclk_d      <= bclk_sr[SYNC_STAGES-1];
      bit_tick    <= tick;
      slot_start  <= 1'b0;
      slot_last   <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      if (tick) begin
        lr_prev  <= lr_s;
        pend     <= sync_edge;
        pend_lvl <= lr_s;
        if (active) begin
          bit_cnt     <= nb;
          slot_cnt    <= ns;
          slot_start  <= (nb == '0);
          slot_last   <= (nb == BW'(W_SLOT - 1));
          frame_start <= (nb == '0) && (ns == '0);
        end
        if (apply && ((state == UNLOCKED) || !good_sync)) begin
          err      <= (state == LOCKED);
          state    <= FIRST;
          locked   <= (FIRST == LOCKED);
          good_cnt <= GW'(1);
        end else if (apply) begin
          if (state == ACQUIRE) begin
            good_cnt <= good_inc;
            if (lock_now) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end else if ((state == LOCKED) && missing) begin
          // expected sync never arrived: keep counting but drop lock
          err      <= 1'b1;
          state    <= ACQUIRE;
          locked   <= 1'b0;
          good_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_tracker.sv
// tb/tb_i2s_frame_tracker.sv - randomized self-checking bench for i2s_frame_tracker
// Instance a: I2S defaults; instance b: TDM, 8 slots of 16 bits, no delay.
module tb_i2s_frame_tracker;

  typedef struct packed {
    logic       tick;
    logic [4:0] bitc;
    logic [2:0] slot;
    logic       ss, sl, fs, lk, er;
  } obs_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic bclk_a = 1'b1, lr_a = 1'b0, bclk_b = 1'b1, lr_b = 1'b0;
  logic       bt_a, ss_a, sl_a, fs_a, lk_a, er_a;
  logic [4:0] bc_a;
  logic [0:0] sc_a;
  logic       bt_b, ss_b, sl_b, fs_b, lk_b, er_b;
  logic [3:0] bc_b;
  logic [2:0] sc_b;

  int n_checks = 0, n_fail = 0;
  int ka, pa, kb, pb, wd, fdrop;

  int   m_w[2]     = '{32, 16};
  int   m_n[2]     = '{2, 8};
  int   m_mode[2]  = '{0, 1};
  int   m_delay[2] = '{1, 0};
  int   m_st[2], m_pos[2], m_good[2];
  logic m_prev[2], m_pend[2], m_plvl[2];

  always #5 clk = ~clk;

  i2s_frame_tracker u_a (
    .clk(clk), .rst_n(rst_n), .bclk(bclk_a), .lrclk(lr_a),
    .bit_tick(bt_a), .bit_cnt(bc_a), .slot_cnt(sc_a), .slot_start(ss_a),
    .slot_last(sl_a), .frame_start(fs_a), .locked(lk_a), .err(er_a)
  );

  i2s_frame_tracker #(.W_SLOT(16), .N_SLOTS(8), .SYNC_MODE(1), .DELAY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bclk(bclk_b), .lrclk(lr_b),
    .bit_tick(bt_b), .bit_cnt(bc_b), .slot_cnt(sc_b), .slot_start(ss_b),
    .slot_last(sl_b), .frame_start(fs_b), .locked(lk_b), .err(er_b)
  );

  function automatic obs_t read_obs(input int d);
    if (d == 0) return {bt_a, bc_a, 2'b00, sc_a, ss_a, sl_a, fs_a, lk_a, er_a};
    return {bt_b, 1'b0, bc_b, sc_b, ss_b, sl_b, fs_b, lk_b, er_b};
  endfunction

  function automatic logic pulses(input int d);
    if (d == 0) return bt_a | ss_a | sl_a | fs_a | er_a;
    return bt_b | ss_b | sl_b | fs_b | er_b;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_pos[d] = 0; m_good[d] = 0;
      m_prev[d] = 1'b0; m_pend[d] = 1'b0; m_plvl[d] = 1'b0;
    end
  endtask

  // Position is tracked as one index into the frame; bit/slot are derived from it.
  task automatic model_step(input int d, input logic lr, output obs_t e);
    logic edg, app, lvl, er, act;
    int   nat, tgt, b, s;
    edg = (m_mode[d] != 0) ? (lr && !m_prev[d]) : (lr != m_prev[d]);
    m_prev[d] = lr;
    if (m_delay[d] == 0) begin
      app = edg; lvl = lr;
    end else begin
      app = m_pend[d]; lvl = m_plvl[d]; m_pend[d] = edg; m_plvl[d] = lr;
    end
    nat = (m_pos[d] + 1) % (m_w[d] * m_n[d]);
    tgt = (m_mode[d] != 0) ? 0 : (lvl ? m_w[d] : 0);
    er  = 1'b0;
    if (m_st[d] == 0) begin
      if (app) begin m_pos[d] = tgt; m_good[d] = 1; m_st[d] = 1; end
    end else if (app && tgt == nat) begin
      m_pos[d] = nat;
      if (m_st[d] == 1) begin
        m_good[d]++;
        if (m_good[d] >= 2) m_st[d] = 2;
      end
    end else if (app) begin
      er = (m_st[d] == 2); m_pos[d] = tgt; m_good[d] = 1; m_st[d] = 1;
    end else begin
      m_pos[d] = nat;
      if (m_st[d] == 2 && ((m_mode[d] != 0) ? (nat == 0) : (nat % m_w[d] == 0))) begin
        er = 1'b1; m_st[d] = 1; m_good[d] = 0;
      end
    end
    act = (m_st[d] != 0);
    b = act ? m_pos[d] % m_w[d] : 0;
    s = act ? m_pos[d] / m_w[d] : 0;
    e = {1'b1, 5'(b), 3'(s), act && b == 0, act && b == m_w[d] - 1,
         act && b == 0 && s == 0, m_st[d] == 2, er};
  endtask

  task automatic drive_bit(input int d, input logic lr, output obs_t o, output logic p);
    if (d == 0) begin bclk_a = 1'b0; lr_a = lr; end
    else begin bclk_b = 1'b0; lr_b = lr; end
    repeat (3) @(negedge clk);
    o = read_obs(d);
    @(negedge clk);
    p = pulses(d);
    if (d == 0) bclk_a = 1'b1; else bclk_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic lr_i2s();
    return 1'((ka + pa) / 32 % 2);
  endfunction

  function automatic logic lr_tdm();
    return ((kb + pb) % 128 < wd) && ((kb + pb) / 128 != fdrop);
  endfunction

  task automatic test_reset();
    obs_t o;
    n_checks++;
    if (read_obs(0) !== '0 || read_obs(1) !== '0) begin
      n_fail++;
      $display("FAIL reset_held got a=%h b=%h exp 0", read_obs(0), read_obs(1));
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    o = read_obs(0);
    n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_released got %h exp 0", o); end
  endtask

  task automatic test_i2s_lock();
    obs_t o, e; logic p, lr; int fs_cnt = 0;
    pa = $urandom_range(1, 31); ka = 0;
    for (int i = 0; i < 384; i++) begin
      lr = lr_i2s();
      model_step(0, lr, e); drive_bit(0, lr, o, p); ka++;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL i2s_lock tick %0d got %h exp %h", i, o, e); end
      n_checks++;
      if (p !== 1'b0) begin n_fail++; $display("FAIL i2s_lock_pulse tick %0d got %b exp 0", i, p); end
      if (i >= 256 && o.fs) fs_cnt++;
    end
    n_checks++;
    if (fs_cnt !== 2) begin n_fail++; $display("FAIL i2s_frame_count got %0d exp 2", fs_cnt); end
    n_checks++;
    if (lk_a !== 1'b1) begin n_fail++; $display("FAIL i2s_locked got %b exp 1", lk_a); end
  endtask

  task automatic test_i2s_early();
    obs_t o, e; logic p, lr; int errs = 0, guard = 0;
    while ((ka + pa) % 32 != 10 && guard < 64) begin
      lr = lr_i2s(); model_step(0, lr, e); drive_bit(0, lr, o, p); ka++; guard++;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL i2s_pre_early got %h exp %h", o, e); end
    end
    pa++;
    for (int i = 0; i < 128; i++) begin
      lr = lr_i2s();
      model_step(0, lr, e); drive_bit(0, lr, o, p); ka++;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL i2s_early tick %0d got %h exp %h", i, o, e); end
      n_checks++;
      if (p !== 1'b0) begin n_fail++; $display("FAIL i2s_early_pulse tick %0d got %b exp 0", i, p); end
      if (o.er) errs++;
    end
    n_checks++;
    if (errs !== 1) begin n_fail++; $display("FAIL i2s_early_err_count got %0d exp 1", errs); end
    n_checks++;
    if (lk_a !== 1'b1) begin n_fail++; $display("FAIL i2s_relocked got %b exp 1", lk_a); end
  endtask

  task automatic test_bclk_stall();
    obs_t o, e; logic p, lr; logic [4:0] held; int seen = 0, moved = 0, errs = 0;
    int pre = $urandom_range(3, 20);
    for (int i = 0; i < pre; i++) begin
      lr = lr_i2s(); model_step(0, lr, e); drive_bit(0, lr, o, p); ka++;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL stall_pre got %h exp %h", o, e); end
    end
    held = bc_a;
    repeat (1000) begin
      @(negedge clk);
      if (bt_a) seen++;
      if (bc_a !== held) moved++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL stall_ticks got %0d exp 0", seen); end
    n_checks++;
    if (moved !== 0) begin n_fail++; $display("FAIL stall_frozen got %0d changes exp 0", moved); end
    for (int i = 0; i < 100; i++) begin
      lr = lr_i2s(); model_step(0, lr, e); drive_bit(0, lr, o, p); ka++;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL stall_resume tick %0d got %h exp %h", i, o, e); end
      if (o.er) errs++;
    end
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL stall_err_count got %0d exp 0", errs); end
  endtask

  task automatic test_reset_midframe();
    obs_t o, e; logic p, lr; int guard = 0;
    while (m_pos[0] != 49 && guard < 128) begin
      lr = lr_i2s(); model_step(0, lr, e); drive_bit(0, lr, o, p); ka++; guard++;
    end
    n_checks++;
    if (bc_a !== 5'd17 || sc_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_position got bit %0d slot %0d exp 17/1", bc_a, sc_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (read_obs(0) !== '0) begin n_fail++; $display("FAIL reset_async got %h exp 0", read_obs(0)); end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      model_step(0, 1'b0, e); drive_bit(0, 1'b0, o, p);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_idle tick %0d got %h exp %h", i, o, e); end
    end
  endtask

  task automatic run_tdm(input string name, input int n, output int errs, output int fss);
    obs_t o, e; logic p, lr;
    errs = 0; fss = 0;
    for (int i = 0; i < n; i++) begin
      lr = lr_tdm();
      model_step(1, lr, e); drive_bit(1, lr, o, p); kb++;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s tick %0d got %h exp %h", name, i, o, e); end
      n_checks++;
      if (p !== 1'b0) begin n_fail++; $display("FAIL %s_pulse tick %0d got %b exp 0", name, i, p); end
      if (o.er) errs++;
      if (o.fs && i >= n - 128) fss++;
    end
  endtask

  task automatic test_tdm_lock();
    int errs, fss;
    pb = $urandom_range(1, 127); kb = 0; wd = 1; fdrop = -1;
    run_tdm("tdm_lock", 512, errs, fss);
    n_checks++;
    if (fss !== 1) begin n_fail++; $display("FAIL tdm_frame_count got %0d exp 1", fss); end
    n_checks++;
    if (lk_b !== 1'b1) begin n_fail++; $display("FAIL tdm_locked got %b exp 1", lk_b); end
  endtask

  task automatic test_tdm_drop();
    int errs, fss;
    fdrop = (kb + pb) / 128 + 1;
    run_tdm("tdm_drop", 512, errs, fss);
    n_checks++;
    if (errs !== 1) begin n_fail++; $display("FAIL tdm_drop_err_count got %0d exp 1", errs); end
    n_checks++;
    if (lk_b !== 1'b1) begin n_fail++; $display("FAIL tdm_relocked got %b exp 1", lk_b); end
  endtask

  task automatic test_tdm_width();
    int errs, fss, adv;
    adv = (228 - (kb + pb) % 128) % 128;
    run_tdm("tdm_align", adv, errs, fss);
    wd = $urandom_range(2, 60);
    run_tdm("tdm_width", 384, errs, fss);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL tdm_width_err_count got %0d exp 0", errs); end
    n_checks++;
    if (lk_b !== 1'b1) begin n_fail++; $display("FAIL tdm_width_locked got %b exp 1", lk_b); end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_i2s_lock();
    test_i2s_early();
    test_bclk_stall();
    test_reset_midframe();
    test_tdm_lock();
    test_tdm_drop();
    test_tdm_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
